// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   UART_DATA_BITS : payload bits per frame (8N1 framing)
//   rx_state_t     : receiver FSM state encoding
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO holding received bytes.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data this cycle (accepted if not full, or if popping)
//   push_data  : byte to store
//   pop        : consume the head entry (ignored when empty)
//   rd_data    : registered head entry; holds its last value while empty, 0 after reset
//   empty      : no entries stored
//   full       : DEPTH entries stored
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // The head register is loaded with whatever will sit at the read pointer;
    // a byte written into the slot that becomes the head bypasses memory.
    if (count_d != '0) begin
      if (do_push && (rd_ptr_d == wr_ptr_q)) head_d = push_data;
      else                                    head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller.
// Synchronizes RXD, samples start/data/stop bits at mid-bit, validates the
// frame and pushes good bytes into a FIFO drained over a valid/ready handshake.
//   clk, reset : clock, asynchronous active-high reset
//   RXD        : serial input, idle high, asynchronous to clk
//   rx_data    : FIFO head byte (held when empty)
//   rx_valid   : FIFO non-empty
//   rx_ready   : consumer accepts the head byte this cycle
//   rx_busy    : frame in progress
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, good byte dropped because the FIFO was full
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  // Two-flop synchronizer, reset to the idle line level.
  logic rxd_meta_q, rxs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxs        <= 1'b1;
    end else begin
      rxd_meta_q <= RXD;
      rxs        <= rxd_meta_q;
    end
  end

  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      fifo_push, fifo_pop, fifo_empty, fifo_full;

  assign rx_valid  = !fifo_empty;
  assign fifo_pop  = rx_valid && rx_ready;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    fifo_push   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Line went back high before mid-bit: noise, not a start bit.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rxs;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          // Leave at mid stop bit so a following start edge is caught at once.
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs) begin
            if (!fifo_full || fifo_pop) fifo_push = 1'b1;
            else                        overrun_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // The byte pushed at the stop sample includes the final data bit, which was
  // captured into shreg_q a full bit period earlier.
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (shreg_q),
    .pop       (fifo_pop),
    .rd_data   (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed frames with a byte scoreboard.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];

  int unsigned last_t0 = 0;
  int unsigned valid_hi = 0, valid_rise_cyc = 0;
  int unsigned busy_rises = 0, busy_rise_cyc = 0;
  int unsigned fe_cnt = 0, fe_cyc = 0;
  int unsigned ov_cnt = 0, ov_cyc = 0;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RXD       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Inputs change 2 time units after the rising edge; outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic clear_stats();
    valid_hi = 0; valid_rise_cyc = 0;
    busy_rises = 0; busy_rise_cyc = 0;
    fe_cnt = 0; fe_cyc = 0;
    ov_cnt = 0; ov_cyc = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    last_t0 = cyc + 1;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
    rxd = stop;
    repeat (CPB) tick();
    rxd = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      tick();
      i++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: scoreboard compare on every accepted byte, plus event logging.
  initial begin
    logic [7:0] e;
    logic valid_prev = 1'b0;
    logic busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rx_valid) valid_hi++;
        if (rx_valid && !valid_prev) valid_rise_cyc = cyc;
        if (rx_busy && !busy_prev) begin
          busy_rises++;
          busy_rise_cyc = cyc;
        end
        if (frame_err) begin
          fe_cnt++;
          fe_cyc = cyc;
        end
        if (overrun) begin
          ov_cnt++;
          ov_cyc = cyc;
        end
        if (rx_valid && rx_ready) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got %02h, required no byte", rx_data);
          end else begin
            e = exp_q.pop_front();
            if (rx_data !== e) begin
              n_fail++;
              $display("FAIL pop_data: got %02h, required %02h", rx_data, e);
            end
          end
        end
      end
      valid_prev = rx_valid;
      busy_prev  = rx_busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    repeat (3) tick();
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_busy", 32'(rx_busy), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    repeat (5) tick();

    // Single byte with consumer always ready.
    clear_stats();
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (20) tick();
    check("single_drained", 32'(exp_q.size()), 32'd0);
    check("single_valid_time", valid_rise_cyc, last_t0 + 154);
    check("single_valid_width", valid_hi, 32'd1);
    check("single_busy_time", busy_rise_cyc, last_t0 + 2);
    check("single_frame_err", fe_cnt, 32'd0);
    check("single_overrun", ov_cnt, 32'd0);
    check("single_hold_data", 32'(rx_data), 32'hA5);

    // Short low glitch rejected at mid start bit.
    clear_stats();
    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    repeat (30) tick();
    check("glitch_busy_seen", busy_rises, 32'd1);
    check("glitch_busy_end", 32'(rx_busy), 32'd0);
    check("glitch_no_valid", valid_hi, 32'd0);
    check("glitch_flags", fe_cnt + ov_cnt, 32'd0);

    // Framing error: stop bit held low.
    clear_stats();
    send_frame(8'h3C, 1'b0);
    repeat (40) tick();
    check("ferr_count", fe_cnt, 32'd1);
    check("ferr_time", fe_cyc, last_t0 + 154);
    check("ferr_no_valid", valid_hi, 32'd0);
    check("ferr_no_overrun", ov_cnt, 32'd0);
    check("ferr_idle", 32'(rx_busy), 32'd0);

    // Overrun: five back-to-back bytes into a 4-entry FIFO with no consumer.
    clear_stats();
    rx_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    repeat (20) tick();
    check("ovr_count", ov_cnt, 32'd1);
    check("ovr_time", ov_cyc, last_t0 + 154);
    check("ovr_no_ferr", fe_cnt, 32'd0);
    check("ovr_head", 32'(rx_data), 32'h01);
    rx_ready = 1'b1;
    wait_drain("ovr_drain");
    repeat (3) tick();
    rx_ready = 1'b0;
    check("ovr_empty", 32'(rx_valid), 32'd0);
    check("ovr_hold_data", 32'(rx_data), 32'h04);

    // Full FIFO with a pop on the same edge as the fifth byte's stop sample.
    clear_stats();
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    exp_q.push_back(8'h05);
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (154) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    repeat (20) tick();
    check("fullpop_no_overrun", ov_cnt, 32'd0);
    check("fullpop_occupancy", 32'(exp_q.size()), 32'd4);
    check("fullpop_head", 32'(rx_data), 32'h02);
    rx_ready = 1'b1;
    wait_drain("fullpop_drain");
    repeat (3) tick();
    check("fullpop_last", 32'(rx_data), 32'h05);

    // Reset during data bit 3 of 0xFF, then a clean frame.
    clear_stats();
    rxd = 1'b0;
    repeat (CPB) tick();
    rxd = 1'b1;
    repeat (56) tick();
    check("rst_busy_before", 32'(rx_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_flags", 32'({frame_err, overrun}), 32'd0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    clear_stats();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (20) tick();
    wait_drain("rst_after_frame");
    check("rst_after_flags", fe_cnt + ov_cnt, 32'd0);
    check("rst_after_data", 32'(rx_data), 32'h81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-path controller for the UART. It oversamples the serial `RXD` line, sequences start/data/stop bit sampling and validates each frame. Good bytes go into a small FIFO, which the host drains over a valid/ready handshake. Framing errors and overruns are reported as single-cycle pulses. It sits between the `RXD` pin and the host-side byte consumer.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; even, ≥ 4
- `FIFO_DEPTH`, 4, received-byte buffer entries; power of two, ≥ 2
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- `RXD`  in  1  serial input, idle high, asynchronous to `clk`
- `rx_data`  out  8  FIFO head byte; reset 0
- `rx_valid`  out  1  FIFO non-empty; reset 0
- `rx_ready`  in  1  consumer accepts head byte this cycle
- `rx_busy`  out  1  frame in progress (state ≠ IDLE); reset 0
- `frame_err`  out  1  one-cycle pulse, stop bit sampled 0; reset 0
- `overrun`  out  1  one-cycle pulse, good byte dropped (FIFO full); reset 0

## Operation
- `RXD` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.
- Bit counter width is $clog2(CLKS_PER_BIT). Bit index is 3 bits. The shift register is 8 bits, filled LSB first.
- **IDLE:** when `rxs` = 0, go to START and clear the counter.
- **START:** count CLKS_PER_BIT/2 cycles to mid-bit.
  - If `rxs` = 0 at mid-bit, go to DATA, clear the counter, set bit index to 0.
  - If `rxs` = 1 at mid-bit, treat it as a glitch: return to IDLE with no flags.
- **DATA:** every CLKS_PER_BIT cycles, shift `rxs` into bit[index] and increment index. After bit 7, go to STOP.
- **STOP:** after CLKS_PER_BIT cycles, sample `rxs`, then return to IDLE.
  - `rxs` = 1 and FIFO not full: push the byte.
  - `rxs` = 1, FIFO full, and a pop occurs the same cycle: push the byte; occupancy stays unchanged.
  - `rxs` = 1, FIFO full, and no pop: drop the byte and pulse `overrun`.
  - `rxs` = 0: discard the byte and pulse `frame_err`. The FIFO is untouched.
- Returning to IDLE at stop mid-bit is intentional. The next start edge is accepted immediately, so back-to-back frames are supported.
- **FIFO:**
  - `rx_valid` = (count ≠ 0).
  - `rx_data` = mem[rd_ptr]. Hold `rx_data` at its last value when empty.
  - Pop when `rx_valid && rx_ready`. `rx_ready` while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- **Reset at any time**, including mid-frame:
  - state IDLE, counters 0, FIFO emptied;
  - all outputs at their reset values;
  - a partial frame is discarded without flags.

## Timing
- Let t0 be the first clock edge that samples `RXD` low.
- Synchronizer latency is 2 cycles: `rxs` is low from t0+2, and `rx_busy` rises at t0+3.
- The push edge is at t0 + 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT. For CLKS_PER_BIT = 16 this is t0+154.
- `rx_valid` and the new `rx_data` are visible the cycle after the push edge (t0+155 for CLKS_PER_BIT = 16).
- `frame_err` and `overrun` are high for exactly the cycle after the stop-sample edge.
- `rx_busy` falls the same cycle.
- A pop takes effect at the edge where `rx_valid && rx_ready`. The next head appears the following cycle.
- The FIFO never sees both a push and an overrun for the same frame.

## Structure
- Package `uart_pkg` holds:
  - state enum `rx_state_t` {IDLE, START, DATA, STOP};
  - `UART_DATA_BITS` = 8;
  - shared with the transmitter side.
- Sub-module `uart_rx_fifo` provides a parameterized synchronous FIFO:
  - ports: push, push_data, pop, rd_data, empty, full;
  - reset is asynchronous, active-high.
- `uart_rx_ctrl` contains the synchronizer, FSM, counters and shift register, and instantiates `uart_rx_fifo`.

## Test plan
- **Single byte:** CLKS_PER_BIT = 16; send 0xA5 (8N1), `rx_ready` = 1. Expect `rx_valid` at t0+155 with `rx_data` = 0xA5, then drop after one cycle. No flags.
- **Glitch:** drive `RXD` low for 4 cycles, then high. Expect `rx_busy` high briefly, return to IDLE, no push, no flags.
- **Framing error:** send 0x3C with the stop bit held 0. Expect a `frame_err` pulse at t0+155 and `rx_valid` to stay 0.
- **Overrun:** `rx_ready` = 0; send 0x01–0x05 back to back. Expect the FIFO to hold 0x01–0x04 and one `overrun` pulse on byte 5. Draining then yields 0x01, 0x02, 0x03, 0x04 in order.
- **Full with simultaneous pop:** FIFO full and byte 5 stop edge coincides with `rx_ready` = 1. Expect no `overrun`, 0x01 popped, 0x05 stored last.
- **Reset mid-frame:** assert `reset` during DATA bit 3 of 0xFF. Expect all outputs 0 immediately. Then a clean frame of 0x81 is received correctly.
